mem_stage_cached: RTL and testbench

Parametrised MIPS memory stage: the E→M pipeline register plus an integrated direct-mapped, write-through, no-write-allocate data cache with a generic line-fill/word-write memory port. It replaces the fixed 512-bit, word-only, always-ready stage with configurable geometry, sub-word loads and stores, and a ready/valid memory handshake. It raises `busyM` to the hazard unit while a miss or store is outstanding.

---
 rtl/mem_pkg.sv | 53 +++++
 rtl/dcache_array.sv | 52 +++++
 rtl/mem_stage_cached.sv | 197 +++++++++++++++++++
 tb/tb_mem_stage_cached.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the cached MIPS memory stage.
// Sub-word helpers are only used when MEM_SUBWORD_EN is defined.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FILL_REQ  = 2'd1,
    FILL_WAIT = 2'd2,
    WR_REQ    = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Picks the addressed byte/half out of a word and sign- or zero-extends it.
  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] lo,
                                               input logic [1:0] size, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lo, 3'b000} +: 8];
    h = lo[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: r = uns ? {24'b0, b} : {{24{b[7]}}, b};
      SZ_HALF: r = uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] store_strobe(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] s;
    case (size)
      SZ_BYTE: s = 4'b0001 << lo;
      SZ_HALF: s = lo[1] ? 4'b1100 : 4'b0011;
      default: s = 4'hF;
    endcase
    return s;
  endfunction

  // Replicates sub-word store data so it lands on whichever lanes the strobe enables.
  function automatic logic [31:0] store_lanes(input logic [31:0] data, input logic [1:0] size);
    logic [31:0] r;
    case (size)
      SZ_BYTE: r = {4{data[7:0]}};
      SZ_HALF: r = {2{data[15:0]}};
      default: r = data;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag, valid and data storage for the direct-mapped data cache.
// Combinational read; one write port for either a full-line fill or a strobed word.
module dcache_array
  import mem_pkg::*;
#(
  parameter int LINES      = 64,
  parameter int LINE_WORDS = 16,
  parameter int TAG_W      = 20,
  localparam int IDX_W     = $clog2(LINES),
  localparam int WSEL_W    = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [IDX_W-1:0]        index,
  output logic                    rd_valid,
  output logic [TAG_W-1:0]        rd_tag,
  output logic [LINE_WORDS*32-1:0] rd_line,
  input  logic                    fill_en,
  input  logic [TAG_W-1:0]        fill_tag,
  input  logic [LINE_WORDS*32-1:0] fill_line,
  input  logic                    wr_en,
  input  logic [WSEL_W-1:0]       wr_word,
  input  logic [3:0]              wr_strb,
  input  logic [31:0]             wr_data
);

  logic [LINES-1:0]          valid;
  logic [TAG_W-1:0]          tags [LINES];
  logic [LINE_WORDS*32-1:0]  data [LINES];

  assign rd_valid = valid[index];
  assign rd_tag   = tags[index];
  assign rd_line  = data[index];

  // Reset wins over a fill arriving in the same cycle, so an abandoned fill never validates.
  always_ff @(posedge clk) begin
    if (rst) valid <= '0;
    else if (fill_en) valid[index] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      tags[index] <= fill_tag;
      data[index] <= fill_line;
    end else if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_strb[b]) data[index][int'(wr_word) * 32 + b * 8 +: 8] <= wr_data[b * 8 +: 8];
      end
    end
  end

endmodule

// File: rtl/mem_stage_cached.sv
// E->M pipeline register plus write-through, no-write-allocate direct-mapped data cache.
// Optional feature macro: MEM_SUBWORD_EN enables byte/half loads and stores.
module mem_stage_cached
  import mem_pkg::*;
#(
  parameter int LINES      = 64,
  parameter int LINE_WORDS = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stallM,
  input  logic                     jumpE,
  input  logic                     RegWriteE,
  input  logic                     MemWriteE,
  input  logic                     MemReadE,
  input  logic [1:0]               MemSizeE,
  input  logic                     MemUnsignedE,
  input  logic [4:0]               WriteRegE,
  input  logic [31:0]              ALUOutE,
  input  logic [31:0]              WriteDataE,
  input  logic [31:0]              PCPlus4E,
  output logic                     jumpM,
  output logic                     RegWriteM,
  output logic                     MemReadM,
  output logic [4:0]               WriteRegM,
  output logic [31:0]              ALUOutM,
  output logic [31:0]              PCPlus8M,
  output logic [31:0]              ReadDataM,
  output logic                     busyM,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic                     mem_req_we,
  output logic [31:0]              mem_req_addr,
  output logic [31:0]              mem_req_wdata,
  output logic [3:0]               mem_req_wstrb,
  input  logic                     mem_rsp_valid,
  input  logic [LINE_WORDS*32-1:0] mem_rsp_data
);

  localparam int WOFF_W  = $clog2(LINE_WORDS);
  localparam int IDX_W   = $clog2(LINES);
  localparam int IDX_LSB = 2 + WOFF_W;
  localparam int TAG_W   = 32 - IDX_LSB - IDX_W;
  localparam int WSEL_W  = (LINE_WORDS > 1) ? WOFF_W : 1;

  logic        MemWriteM;
  logic [31:0] WriteDataM;
  logic [31:0] PCPlus4M;
`ifdef MEM_SUBWORD_EN
  logic [1:0]  MemSizeM;
  logic        MemUnsignedM;
`else
  logic        unused_cfg;
  assign unused_cfg = ^{MemSizeE, MemUnsignedE};
`endif

  state_t                   state;
  logic                     done;
  logic                     hit;
  logic                     load_en;
  logic                     rd_valid;
  logic [TAG_W-1:0]         rd_tag;
  logic [LINE_WORDS*32-1:0] rd_line;
  logic [IDX_W-1:0]         addr_index;
  logic [TAG_W-1:0]         addr_tag;
  logic [WSEL_W-1:0]        word_sel;
  logic [31:0]              cur_word;
  logic [31:0]              st_data;
  logic [3:0]               st_strb;

  assign addr_index = ALUOutM[IDX_LSB +: IDX_W];
  assign addr_tag   = ALUOutM[31 -: TAG_W];

  generate
    if (LINE_WORDS > 1) begin : g_wsel
      assign word_sel = ALUOutM[2 +: WOFF_W];
    end else begin : g_wsel_one
      assign word_sel = '0;
    end
  endgenerate

  assign cur_word = rd_line[int'(word_sel) * 32 +: 32];
  assign hit      = rd_valid && (rd_tag == addr_tag);
  assign busyM    = (state != IDLE) || (MemReadM && !hit) || (MemWriteM && !done);
  assign load_en  = !stallM && !busyM;
  assign PCPlus8M = PCPlus4M + 32'd4;

`ifdef MEM_SUBWORD_EN
  assign st_data   = store_lanes(WriteDataM, MemSizeM);
  assign st_strb   = store_strobe(MemSizeM, ALUOutM[1:0]);
  assign ReadDataM = MemReadM ? load_extend(cur_word, ALUOutM[1:0], MemSizeM, MemUnsignedM) : 32'd0;
`else
  assign st_data   = WriteDataM;
  assign st_strb   = 4'hF;
  assign ReadDataM = MemReadM ? cur_word : 32'd0;
`endif

  dcache_array #(
    .LINES      (LINES),
    .LINE_WORDS (LINE_WORDS),
    .TAG_W      (TAG_W)
  ) u_array (
    .clk       (clk),
    .rst       (rst),
    .index     (addr_index),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_line   (rd_line),
    .fill_en   ((state == FILL_WAIT) && mem_rsp_valid),
    .fill_tag  (addr_tag),
    .fill_line (mem_rsp_data),
    .wr_en     ((state == WR_REQ) && mem_req_ready && hit),
    .wr_word   (word_sel),
    .wr_strb   (st_strb),
    .wr_data   (st_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      jumpM      <= 1'b0;
      RegWriteM  <= 1'b0;
      MemReadM   <= 1'b0;
      MemWriteM  <= 1'b0;
      WriteRegM  <= '0;
      ALUOutM    <= '0;
      WriteDataM <= '0;
      PCPlus4M   <= '0;
`ifdef MEM_SUBWORD_EN
      MemSizeM     <= '0;
      MemUnsignedM <= 1'b0;
`endif
    end else if (load_en) begin
      jumpM      <= jumpE;
      RegWriteM  <= RegWriteE;
      MemReadM   <= MemReadE;
      MemWriteM  <= MemWriteE;
      WriteRegM  <= WriteRegE;
      ALUOutM    <= ALUOutE;
      WriteDataM <= WriteDataE;
      PCPlus4M   <= PCPlus4E;
`ifdef MEM_SUBWORD_EN
      MemSizeM     <= MemSizeE;
      MemUnsignedM <= MemUnsignedE;
`endif
    end
  end

  // done marks a store already written so a stalled op is not reissued.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      done          <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_req_we    <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
      mem_req_wstrb <= '0;
    end else begin
      if (load_en) done <= 1'b0;
      case (state)
        IDLE: begin
          if (MemReadM && !hit) begin
            state         <= FILL_REQ;
            mem_req_valid <= 1'b1;
            mem_req_we    <= 1'b0;
            mem_req_addr  <= {ALUOutM[31:IDX_LSB], {IDX_LSB{1'b0}}};
          end else if (MemWriteM && !done) begin
            state         <= WR_REQ;
            mem_req_valid <= 1'b1;
            mem_req_we    <= 1'b1;
            mem_req_addr  <= {ALUOutM[31:2], 2'b00};
            mem_req_wdata <= st_data;
            mem_req_wstrb <= st_strb;
          end
        end
        FILL_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= FILL_WAIT;
          end
        end
        FILL_WAIT: begin
          if (mem_rsp_valid) state <= IDLE;
        end
        WR_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            done          <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_cached.sv
// Directed, table-driven bench for mem_stage_cached with a simple backing-memory responder.
// Sub-word expectations switch on MEM_SUBWORD_EN to match the build under test.
module tb_mem_stage_cached;
  import mem_pkg::*;

  localparam int LINES = 64;
  localparam int LW    = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            stallM, jumpE, RegWriteE, MemWriteE, MemReadE, MemUnsignedE;
  logic [1:0]      MemSizeE;
  logic [4:0]      WriteRegE;
  logic [31:0]     ALUOutE, WriteDataE, PCPlus4E;
  logic            jumpM, RegWriteM, MemReadM, busyM;
  logic [4:0]      WriteRegM;
  logic [31:0]     ALUOutM, PCPlus8M, ReadDataM;
  logic            mem_req_valid, mem_req_ready, mem_req_we, mem_rsp_valid;
  logic [31:0]     mem_req_addr, mem_req_wdata;
  logic [3:0]      mem_req_wstrb;
  logic [LW*32-1:0] mem_rsp_data;

  always #5 clk = ~clk;

  mem_stage_cached #(.LINES(LINES), .LINE_WORDS(LW)) dut (
    .clk(clk), .rst(rst), .stallM(stallM), .jumpE(jumpE), .RegWriteE(RegWriteE),
    .MemWriteE(MemWriteE), .MemReadE(MemReadE), .MemSizeE(MemSizeE), .MemUnsignedE(MemUnsignedE),
    .WriteRegE(WriteRegE), .ALUOutE(ALUOutE), .WriteDataE(WriteDataE), .PCPlus4E(PCPlus4E),
    .jumpM(jumpM), .RegWriteM(RegWriteM), .MemReadM(MemReadM), .WriteRegM(WriteRegM),
    .ALUOutM(ALUOutM), .PCPlus8M(PCPlus8M), .ReadDataM(ReadDataM), .busyM(busyM),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
  );

  typedef struct {
    bit          rd;
    bit          wr;
    logic [1:0]  size;
    bit          uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    int          exp_stall;
    int          exp_fills;
    int          exp_writes;
    logic [31:0] exp_faddr;
    logic [31:0] exp_waddr;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_wdata;
    logic [31:0] exp_wmask;
  } vec_t;

  vec_t vecs[$];

  logic [31:0] bmem [0:4095];
  int checks = 0, errors = 0;
  int fills = 0, writes = 0, accepts = 0;
  int ready_block = 0, rsp_delay = 0;
  logic [31:0] last_faddr, last_waddr, last_wdata;
  logic [3:0]  last_wstrb;

  // Backing memory: accepts at the posedge that follows a valid&&ready negedge sample.
  initial begin : responder
    bit          pending;
    int          cnt;
    logic [31:0] faddr;
    pending = 0;
    cnt = 0;
    faddr = '0;
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b0;
    mem_rsp_data = '0;
    forever begin
      @(negedge clk);
      if (mem_req_valid && mem_req_ready && !rst) begin
        accepts++;
        if (mem_req_we) begin
          writes++;
          last_waddr = mem_req_addr;
          last_wstrb = mem_req_wstrb;
          last_wdata = mem_req_wdata;
          for (int b = 0; b < 4; b++)
            if (mem_req_wstrb[b]) bmem[mem_req_addr[13:2]][b*8 +: 8] = mem_req_wdata[b*8 +: 8];
        end else begin
          fills++;
          last_faddr = mem_req_addr;
          faddr = mem_req_addr;
          pending = 1;
          cnt = rsp_delay;
        end
      end
      @(posedge clk);
      #1;
      mem_rsp_valid = 1'b0;
      if (pending) begin
        if (cnt == 0) begin
          for (int w = 0; w < LW; w++) mem_rsp_data[w*32 +: 32] = bmem[(int'(faddr[13:2]) + w) % 4096];
          mem_rsp_valid = 1'b1;
          pending = 0;
        end else begin
          cnt--;
        end
      end
      if (mem_req_valid && ready_block > 0) begin
        mem_req_ready = 1'b0;
        ready_block--;
      end else begin
        mem_req_ready = 1'b1;
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_e();
    jumpE = 0; RegWriteE = 0; MemWriteE = 0; MemReadE = 0; MemSizeE = 2'd0; MemUnsignedE = 0;
    WriteRegE = '0; ALUOutE = '0; WriteDataE = '0; PCPlus4E = '0;
  endtask

  // Issues one memory op into M, then waits (bounded) for busyM to fall.
  task automatic apply_stimulus(input bit rd, input bit wr, input logic [1:0] size, input bit uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output logic [31:0] data, output int stall);
    MemReadE = rd; MemWriteE = wr; MemSizeE = size; MemUnsignedE = uns;
    ALUOutE = addr; WriteDataE = wdata; RegWriteE = rd; WriteRegE = 5'd9; PCPlus4E = 32'h400;
    tick();
    clear_e();
    stall = 0;
    while (busyM && stall < 100) begin
      tick();
      stall++;
    end
    data = ReadDataM;
  endtask

  function automatic void ld(input logic [31:0] addr, input logic [1:0] size, input bit uns,
                             input logic [31:0] exp, input int stall, input logic [31:0] faddr);
    vec_t v;
    v = '{rd: 1, wr: 0, size: size, uns: uns, addr: addr, wdata: 0, exp_data: exp,
          exp_stall: stall, exp_fills: (stall == 3) ? 1 : 0, exp_writes: 0, exp_faddr: faddr,
          exp_waddr: 0, exp_wstrb: 0, exp_wdata: 0, exp_wmask: 0};
    vecs.push_back(v);
  endfunction

  function automatic void st(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wdata,
                             input logic [31:0] waddr, input logic [3:0] wstrb,
                             input logic [31:0] ewdata, input logic [31:0] wmask);
    vec_t v;
    v = '{rd: 0, wr: 1, size: size, uns: 0, addr: addr, wdata: wdata, exp_data: 0,
          exp_stall: 2, exp_fills: 0, exp_writes: 1, exp_faddr: 0,
          exp_waddr: waddr, exp_wstrb: wstrb, exp_wdata: ewdata, exp_wmask: wmask};
    vecs.push_back(v);
  endfunction

  initial begin
    logic [31:0] data, cap_addr, cap_wdata;
    logic [3:0]  cap_wstrb;
    int stall, f0, w0, a0, low, bad;
    bit seen;

    for (int i = 0; i < 4096; i++) bmem[i] = 32'h1000_0000 + 32'(i * 4);
    bmem[32'h100 >> 2] = 32'hDEADBEEF;
    bmem[32'h200 >> 2] = 32'h000080FF;

    ld(32'h100, SZ_WORD, 0, 32'hDEADBEEF, 3, 32'h100);
    ld(32'h100, SZ_WORD, 0, 32'hDEADBEEF, 0, 0);
    ld(32'h13C, SZ_WORD, 0, 32'h1000013C, 0, 0);
    st(32'h104, SZ_WORD, 32'hCAFEF00D, 32'h104, 4'hF, 32'hCAFEF00D, 32'hFFFFFFFF);
    ld(32'h104, SZ_WORD, 0, 32'hCAFEF00D, 0, 0);
    st(32'h500, SZ_WORD, 32'h12345678, 32'h500, 4'hF, 32'h12345678, 32'hFFFFFFFF);
    ld(32'h500, SZ_WORD, 0, 32'h12345678, 3, 32'h500);
    ld(32'h140, SZ_WORD, 0, 32'h10000140, 3, 32'h140);
    ld(32'h1100, SZ_WORD, 0, 32'h10001100, 3, 32'h1100);
    ld(32'h104, SZ_WORD, 0, 32'hCAFEF00D, 3, 32'h100);
    st(32'h108, SZ_WORD, 32'hAABBCCDD, 32'h108, 4'hF, 32'hAABBCCDD, 32'hFFFFFFFF);
    st(32'h108, SZ_WORD, 32'h11223344, 32'h108, 4'hF, 32'h11223344, 32'hFFFFFFFF);
    ld(32'h108, SZ_WORD, 0, 32'h11223344, 0, 0);
`ifdef MEM_SUBWORD_EN
    ld(32'h200, SZ_BYTE, 0, 32'hFFFFFFFF, 3, 32'h200);
    ld(32'h200, SZ_HALF, 1, 32'h000080FF, 0, 0);
    ld(32'h201, SZ_BYTE, 1, 32'h00000080, 0, 0);
    st(32'h203, SZ_BYTE, 32'h0000005A, 32'h200, 4'b1000, 32'h5A000000, 32'hFF000000);
    ld(32'h200, SZ_WORD, 0, 32'h5A0080FF, 0, 0);
    ld(32'h202, SZ_HALF, 0, 32'h00005A00, 0, 0);
    ld(32'h203, SZ_BYTE, 0, 32'h0000005A, 0, 0);
    st(32'h206, SZ_HALF, 32'h0000BEEF, 32'h204, 4'b1100, 32'hBEEF0000, 32'hFFFF0000);
    ld(32'h206, SZ_HALF, 0, 32'hFFFFBEEF, 0, 0);
    ld(32'h204, SZ_WORD, 0, 32'hBEEF0204, 0, 0);
`else
    ld(32'h201, SZ_BYTE, 0, 32'h000080FF, 3, 32'h200);
    st(32'h203, SZ_BYTE, 32'h0000005A, 32'h200, 4'hF, 32'h0000005A, 32'hFFFFFFFF);
    ld(32'h200, SZ_WORD, 0, 32'h0000005A, 0, 0);
    ld(32'h202, SZ_HALF, 0, 32'h0000005A, 0, 0);
`endif

    rst = 1'b1;
    stallM = 1'b0;
    clear_e();
    tick();
    tick();
    check_output("rst_ReadDataM", ReadDataM, 32'd0);
    check_output("rst_PCPlus8M", PCPlus8M, 32'd4);
    check_output("rst_ALUOutM", ALUOutM, 32'd0);
    check_output("rst_ctrl", {27'd0, jumpM, RegWriteM, MemReadM, busyM, mem_req_valid}, 32'd0);
    check_output("rst_WriteRegM", {27'd0, WriteRegM}, 32'd0);
    check_output("rst_wstrb", {28'd0, mem_req_wstrb}, 32'd0);
    rst = 1'b0;
    tick();

    foreach (vecs[i]) begin
      f0 = fills;
      w0 = writes;
      apply_stimulus(vecs[i].rd, vecs[i].wr, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
                     data, stall);
      check_output($sformatf("v%0d_stall", i), 32'(stall), 32'(vecs[i].exp_stall));
      check_output($sformatf("v%0d_fills", i), 32'(fills - f0), 32'(vecs[i].exp_fills));
      check_output($sformatf("v%0d_writes", i), 32'(writes - w0), 32'(vecs[i].exp_writes));
      if (vecs[i].rd) check_output($sformatf("v%0d_data", i), data, vecs[i].exp_data);
      if (vecs[i].exp_fills > 0) check_output($sformatf("v%0d_faddr", i), last_faddr, vecs[i].exp_faddr);
      if (vecs[i].wr) begin
        check_output($sformatf("v%0d_waddr", i), last_waddr, vecs[i].exp_waddr);
        check_output($sformatf("v%0d_wstrb", i), {28'd0, last_wstrb}, {28'd0, vecs[i].exp_wstrb});
        check_output($sformatf("v%0d_wdata", i), last_wdata & vecs[i].exp_wmask, vecs[i].exp_wdata);
      end
    end

    // Control path: non-memory op passes straight through the register.
    jumpE = 1; RegWriteE = 1; WriteRegE = 5'd31; PCPlus4E = 32'h1000; ALUOutE = 32'h40;
    tick();
    clear_e();
    check_output("ctl_jumpM", {31'd0, jumpM}, 32'd1);
    check_output("ctl_WriteRegM", {27'd0, WriteRegM}, 32'd31);
    check_output("ctl_PCPlus8M", PCPlus8M, 32'h1004);
    check_output("ctl_ALUOutM", ALUOutM, 32'h40);
    check_output("ctl_busyM", {31'd0, busyM}, 32'd0);
    tick();
    check_output("ctl_bubble", {31'd0, jumpM}, 32'd0);

    // Write request held off by ready for 5 cycles.
    ready_block = 5;
    a0 = accepts; w0 = writes; low = 0; bad = 0; seen = 0; stall = 0;
    cap_addr = '0; cap_wdata = '0; cap_wstrb = '0;
    MemWriteE = 1; ALUOutE = 32'h10C; WriteDataE = 32'h0BADF00D;
    tick();
    clear_e();
    while (busyM && stall < 50) begin
      tick();
      stall++;
      if (mem_req_valid) begin
        if (!seen) begin
          seen = 1;
          cap_addr = mem_req_addr; cap_wdata = mem_req_wdata; cap_wstrb = mem_req_wstrb;
        end else if (cap_addr !== mem_req_addr || cap_wdata !== mem_req_wdata ||
                     cap_wstrb !== mem_req_wstrb || mem_req_we !== 1'b1) begin
          bad++;
        end
        if (!mem_req_ready) begin
          low++;
          if (!busyM) bad++;
        end
      end
    end
    check_output("rdy_stall", 32'(stall), 32'd7);
    check_output("rdy_low_cycles", 32'(low), 32'd5);
    check_output("rdy_unstable", 32'(bad), 32'd0);
    check_output("rdy_accepts", 32'(accepts - a0), 32'd1);
    check_output("rdy_writes", 32'(writes - w0), 32'd1);
    check_output("rdy_addr", cap_addr, 32'h10C);
    check_output("rdy_wdata", cap_wdata, 32'h0BADF00D);
    apply_stimulus(1, 0, SZ_WORD, 0, 32'h10C, 0, data, stall);
    check_output("rdy_load_data", data, 32'h0BADF00D);
    check_output("rdy_load_stall", 32'(stall), 32'd0);

    // Completed store held in M by stallM must not reissue.
    w0 = writes; bad = 0; stall = 0;
    MemWriteE = 1; ALUOutE = 32'h110; WriteDataE = 32'h77777777;
    tick();
    clear_e();
    stallM = 1'b1;
    while (busyM && stall < 50) begin
      tick();
      stall++;
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      if (mem_req_valid || busyM || ALUOutM !== 32'h110) bad++;
    end
    stallM = 1'b0;
    tick();
    check_output("hold_stall", 32'(stall), 32'd2);
    check_output("hold_reissue", 32'(bad), 32'd0);
    check_output("hold_writes", 32'(writes - w0), 32'd1);
    apply_stimulus(1, 0, SZ_WORD, 0, 32'h110, 0, data, stall);
    check_output("hold_load_data", data, 32'h77777777);

    // Reset while in FILL_WAIT; the late response must be discarded.
    rsp_delay = 2;
    f0 = fills;
    MemReadE = 1; RegWriteE = 1; ALUOutE = 32'h300;
    tick();
    clear_e();
    tick();
    check_output("rfw_req_valid", {31'd0, mem_req_valid}, 32'd1);
    check_output("rfw_req_we", {31'd0, mem_req_we}, 32'd0);
    check_output("rfw_req_addr", mem_req_addr, 32'h300);
    tick();
    check_output("rfw_accepted", 32'(fills - f0), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_output("rfw_valid_dropped", {31'd0, mem_req_valid}, 32'd0);
    check_output("rfw_busy_after_rst", {31'd0, busyM}, 32'd0);
    tick();
    tick();
    check_output("rfw_ignore_rsp", {30'd0, busyM, mem_req_valid}, 32'd0);
    rsp_delay = 0;
    f0 = fills;
    apply_stimulus(1, 0, SZ_WORD, 0, 32'h300, 0, data, stall);
    check_output("rfw_remiss_stall", 32'(stall), 32'd3);
    check_output("rfw_remiss_fills", 32'(fills - f0), 32'd1);
    check_output("rfw_remiss_data", data, 32'h10000300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
